// File: rtl/snake_scan_ctrl_pkg.sv
// snake_scan_ctrl_pkg: shared constants, scan state encoding and width helper
package snake_scan_ctrl_pkg;
  localparam int ROW_FIRST_LAYER = 128;
  localparam int COL_FIRST_LAYER = 128;
  localparam int W_FCOL_DEF = 4;
  localparam int W_PROW_DEF = 3;
  typedef enum logic [2:0] {SCAN_IDLE, SCAN_WLOAD, SCAN_PRIME, SCAN_SNAKE, SCAN_DONE} scan_state_e;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/snake_scan_ctrl_addr_gen.sv
// snake_addr_gen: row/col/linear-address walk, two-row interleaved prime then snake
module snake_addr_gen import snake_scan_ctrl_pkg::*; #(
  parameter int ROW = ROW_FIRST_LAYER,
  parameter int COL = COL_FIRST_LAYER,
  parameter int ADDR_W = $clog2(ROW * COL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  adv,
  output logic [cw(ROW)-1:0]    row,
  output logic [cw(COL)-1:0]    col,
  output logic [ADDR_W-1:0]     addr,
  output logic                  shift_dir,
  output logic                  last_pix,
  output logic                  prime_last
);
  localparam int RW = cw(ROW);
  localparam int CW = cw(COL);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [ADDR_W-1:0] A_COL = ADDR_W'(COL);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic dir_q, dir_d;
  assign row = row_q;
  assign col = col_q;
  assign addr = addr_q;
  assign shift_dir = dir_q;
  assign prime_last = row_q == RW'(1) && col_q == COL_LAST;
  assign last_pix = row_q == ROW_LAST && col_q == (ROW_LAST[0] ? COL_LAST : '0);
  // next pixel: rows 0/1 interleave per column, then each row turns at its end column
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    addr_d = addr_q;
    dir_d = dir_q;
    if (clr || (adv && last_pix)) begin
      row_d = '0;
      col_d = '0;
      addr_d = '0;
      dir_d = 1'b0;
    end else if (adv) begin
      if (row_q == '0) begin
        row_d = RW'(1);
        addr_d = addr_q + A_COL;
      end else if (row_q == RW'(1) && !prime_last) begin
        row_d = '0;
        col_d = col_q + 1'b1;
        addr_d = addr_q - A_COL + 1'b1;
      end else if (dir_q ? col_q == '0 : col_q == COL_LAST) begin
        row_d = row_q + 1'b1;
        addr_d = addr_q + A_COL;
        dir_d = ~dir_q;
      end else begin
        col_d = dir_q ? col_q - 1'b1 : col_q + 1'b1;
        addr_d = dir_q ? addr_q - 1'b1 : addr_q + 1'b1;
      end
    end
  end
  // walk registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
      addr_q <= '0;
      dir_q <= 1'b0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      addr_q <= addr_d;
      dir_q <= dir_d;
    end
  end
endmodule

// File: rtl/snake_scan_ctrl.sv
// snake_scan_ctrl: weight-load then snake-order pixel sequencer for the first conv layer
module snake_scan_ctrl import snake_scan_ctrl_pkg::*; #(
  parameter int ROW = ROW_FIRST_LAYER,
  parameter int COL = COL_FIRST_LAYER,
  parameter int W_FCOL = W_FCOL_DEF,
  parameter int W_PROW = W_PROW_DEF,
  parameter int ADDR_W = $clog2(ROW * COL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               w_ready,
  output logic               w_valid,
  output logic [1:0]         w_fcol,
  output logic [1:0]         w_prow,
  input  logic               px_ready,
  output logic               px_valid,
  output logic [cw(ROW)-1:0] px_row,
  output logic [cw(COL)-1:0] px_col,
  output logic [ADDR_W-1:0]  px_addr,
  output logic               shift_dir,
  output logic               busy,
  output logic               done
);
  scan_state_e state_q, state_d;
  logic [1:0] fcol_q, fcol_d, prow_q, prow_d;
  logic w_hs, px_hs, w_last, last_pix, prime_last;
  assign w_valid = state_q == SCAN_WLOAD;
  assign px_valid = state_q == SCAN_PRIME || state_q == SCAN_SNAKE;
  assign busy = w_valid || px_valid;
  assign done = state_q == SCAN_DONE;
  assign w_fcol = fcol_q;
  assign w_prow = prow_q;
  assign w_hs = w_valid && w_ready;
  assign px_hs = px_valid && px_ready;
  assign w_last = fcol_q == 2'(W_FCOL - 1) && prow_q == 2'(W_PROW - 1);
  snake_addr_gen #(.ROW(ROW), .COL(COL), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .rst_n(rst_n), .clr(abort), .adv(px_hs),
    .row(px_row), .col(px_col), .addr(px_addr), .shift_dir(shift_dir),
    .last_pix(last_pix), .prime_last(prime_last)
  );
  // frame FSM and weight beat counters; abort overrides everything
  always_comb begin
    state_d = state_q;
    fcol_d = fcol_q;
    prow_d = prow_q;
    if (abort) begin
      state_d = SCAN_IDLE;
      fcol_d = '0;
      prow_d = '0;
    end else begin
      unique case (state_q)
        SCAN_IDLE:  state_d = start ? SCAN_WLOAD : SCAN_IDLE;
        SCAN_WLOAD: if (w_hs) begin
          state_d = w_last ? SCAN_PRIME : SCAN_WLOAD;
          prow_d = prow_q == 2'(W_PROW - 1) ? 2'd0 : prow_q + 2'd1;
          fcol_d = w_last ? 2'd0 : prow_q == 2'(W_PROW - 1) ? fcol_q + 2'd1 : fcol_q;
        end
        SCAN_PRIME: state_d = !px_hs ? SCAN_PRIME : last_pix ? SCAN_DONE : prime_last ? SCAN_SNAKE : SCAN_PRIME;
        SCAN_SNAKE: state_d = px_hs && last_pix ? SCAN_DONE : SCAN_SNAKE;
        SCAN_DONE:  state_d = SCAN_IDLE;
        default:    state_d = SCAN_IDLE;
      endcase
    end
  end
  // state and weight counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_IDLE;
      fcol_q <= '0;
      prow_q <= '0;
    end else begin
      state_q <= state_d;
      fcol_q <= fcol_d;
      prow_q <= prow_d;
    end
  end
endmodule

// File: tb/tb_snake_scan_ctrl.sv
// tb_snake_scan_ctrl: scoreboard bench for weight and snake pixel sequencing
module tb_snake_scan_ctrl;
  typedef struct {int row; int col; int addr; bit dir;} pix_t;
  int checks = 0, failures = 0;
  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, w_ready = 1, px_ready = 1;
  logic w_valid, px_valid, shift_dir, busy, done;
  logic [1:0] w_fcol, w_prow, px_row, px_col;
  logic [3:0] px_addr;
  logic start_b = 0, w_ready_b = 1, px_ready_b = 1;
  logic w_valid_b, px_valid_b, shift_dir_b, busy_b, done_b;
  logic [1:0] w_fcol_b, w_prow_b, px_addr_b;
  logic px_row_b, px_col_b;
  always #5 clk = ~clk;
  snake_scan_ctrl #(.ROW(4), .COL(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .w_ready(w_ready),
    .w_valid(w_valid), .w_fcol(w_fcol), .w_prow(w_prow), .px_ready(px_ready),
    .px_valid(px_valid), .px_row(px_row), .px_col(px_col), .px_addr(px_addr),
    .shift_dir(shift_dir), .busy(busy), .done(done)
  );
  snake_scan_ctrl #(.ROW(2), .COL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(1'b0), .w_ready(w_ready_b),
    .w_valid(w_valid_b), .w_fcol(w_fcol_b), .w_prow(w_prow_b), .px_ready(px_ready_b),
    .px_valid(px_valid_b), .px_row(px_row_b), .px_col(px_col_b), .px_addr(px_addr_b),
    .shift_dir(shift_dir_b), .busy(busy_b), .done(done_b)
  );
  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({w_valid, px_valid, busy, done, shift_dir, w_fcol, w_prow, px_row, px_col, px_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {w_valid, px_valid, busy, done, shift_dir, w_fcol, w_prow, px_row, px_col, px_addr});
    end
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || w_valid !== 0) begin
      failures++;
      $display("FAIL reset_idle busy=%b w_valid=%b exp=0", busy, w_valid);
    end
  endtask
  // toggle: px_ready 0/1 alternating; abort_at/rst_at: pixel count to abort/reset after;
  // post: 1 = start during DONE, 2 = start in first IDLE after DONE
  task automatic run_a(input bit toggle, input int abort_at, input int rst_at, input bit start_in_prime, input int post);
    pix_t pq[$];
    pix_t e;
    logic [3:0] wq[$];
    logic [3:0] we;
    logic [8:0] held;
    int n = 0, cyc = 0, wcyc = 0, pcyc = 0, last_hs = -10, done_cyc = -1;
    bit fin = 0, hold_chk = 0, do_abort = 0, do_rst = 0;
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 3; p++) wq.push_back({2'(f), 2'(p)});
    for (int c = 0; c < 3; c++) begin
      pq.push_back('{row: 0, col: c, addr: c, dir: 1'b0});
      pq.push_back('{row: 1, col: c, addr: 3 + c, dir: 1'b0});
    end
    for (int r = 2; r < 4; r++)
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (r % 2 == 0) ? 2 - k : k;
        pq.push_back('{row: r, col: c, addr: r * 3 + c, dir: (r % 2 == 0)});
      end
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    checks++;
    if (w_valid !== 1 || w_fcol !== 0 || w_prow !== 0) begin
      failures++;
      $display("FAIL wload_first got=v%b(%0d,%0d) exp=v1(0,0)", w_valid, w_fcol, w_prow);
    end
    while (!fin && cyc < 200) begin
      px_ready = toggle ? logic'(pcyc % 2) : 1'b1;
      start = start_in_prime && px_valid && n < 3;
      if (hold_chk) begin
        checks++;
        if ({px_row, px_col, px_addr, shift_dir} !== held) begin
          failures++;
          $display("FAIL stall_hold got=%h exp=%h", {px_row, px_col, px_addr, shift_dir}, held);
        end
      end
      hold_chk = px_valid && !px_ready;
      held = {px_row, px_col, px_addr, shift_dir};
      if (w_valid) wcyc++;
      if (w_valid && w_ready) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL weight_extra got=(%0d,%0d) exp=none", w_fcol, w_prow);
        end else begin
          we = wq.pop_front();
          if ({w_fcol, w_prow} !== we) begin
            failures++;
            $display("FAIL weight_beat got=(%0d,%0d) exp=(%0d,%0d)", w_fcol, w_prow, we[3:2], we[1:0]);
          end
        end
      end
      if (px_valid) pcyc++;
      if (px_valid && px_ready) begin
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL pixel_extra got=(%0d,%0d) exp=none", px_row, px_col);
        end else begin
          e = pq.pop_front();
          if (px_row !== e.row || px_col !== e.col || px_addr !== e.addr || shift_dir !== e.dir) begin
            failures++;
            $display("FAIL pixel got=(%0d,%0d,a%0d,d%b) exp=(%0d,%0d,a%0d,d%b)", px_row, px_col, px_addr, shift_dir, e.row, e.col, e.addr, e.dir);
          end
        end
        n++;
        last_hs = cyc;
        do_abort = n == abort_at;
        do_rst = n == rst_at;
      end
      if (do_abort) begin
        abort = 1;
        start = 0;
        @(negedge clk) abort = 0;
        checks++;
        if (px_valid !== 0 || busy !== 0 || w_valid !== 0 || done !== 0) begin
          failures++;
          $display("FAIL abort_idle got=px%b busy%b w%b done%b exp=0000", px_valid, busy, w_valid, done);
        end
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (done !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL abort_no_done got=done%b busy%b exp=00", done, busy);
          end
        end
        return;
      end
      if (do_rst) begin
        start = 0;
        rst_n = 0;
        #1;
        checks++;
        if ({w_valid, px_valid, busy, done, shift_dir, w_fcol, w_prow, px_row, px_col, px_addr} !== '0) begin
          failures++;
          $display("FAIL async_reset got=%b exp=0", {w_valid, px_valid, busy, done, shift_dir, w_fcol, w_prow, px_row, px_col, px_addr});
        end
        @(negedge clk) rst_n = 1;
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (busy !== 0 || px_valid !== 0) begin
            failures++;
            $display("FAIL reset_stay_idle got=busy%b px%b exp=00", busy, px_valid);
          end
        end
        return;
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        start = post == 1;
        checks++;
        if (busy !== 0 || px_valid !== 0) begin
          failures++;
          $display("FAIL done_cycle got=busy%b px%b exp=00", busy, px_valid);
        end
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL frame_timeout got=no_done exp=done");
    end
    checks++;
    if (pq.size() != 0 || wq.size() != 0 || wcyc != 12 || pcyc != (toggle ? 24 : 12)) begin
      failures++;
      $display("FAIL frame_shape got=pix_left%0d w_left%0d wcyc%0d pcyc%0d exp=0 0 12 %0d", pq.size(), wq.size(), wcyc, pcyc, toggle ? 24 : 12);
    end
    checks++;
    if (done_cyc - last_hs != 1) begin
      failures++;
      $display("FAIL done_latency got=%0d exp=1", done_cyc - last_hs);
    end
    start = post == 2;
    checks++;
    if (done !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL done_one_cycle got=done%b busy%b exp=00", done, busy);
    end
    @(negedge clk) start = 0;
    checks++;
    if (w_valid !== (post == 2)) begin
      failures++;
      $display("FAIL post_start got=w_valid%b exp=%b", w_valid, post == 2);
    end
    if (post == 2) begin
      abort = 1;
      @(negedge clk) abort = 0;
    end
  endtask
  task automatic test_row2;
    pix_t pq[$];
    pix_t e;
    int cyc = 0, pc = 0;
    bit fin = 0;
    for (int c = 0; c < 2; c++) begin
      pq.push_back('{row: 0, col: c, addr: c, dir: 1'b0});
      pq.push_back('{row: 1, col: c, addr: 2 + c, dir: 1'b0});
    end
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    while (!fin && cyc < 100) begin
      if (px_valid_b) begin
        pc++;
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL row2_extra got=(%0d,%0d) exp=none", px_row_b, px_col_b);
        end else begin
          e = pq.pop_front();
          if (px_row_b !== 1'(e.row) || px_col_b !== 1'(e.col) || px_addr_b !== 2'(e.addr) || shift_dir_b !== e.dir) begin
            failures++;
            $display("FAIL row2_pixel got=(%0d,%0d,a%0d,d%b) exp=(%0d,%0d,a%0d,d%b)", px_row_b, px_col_b, px_addr_b, shift_dir_b, e.row, e.col, e.addr, e.dir);
          end
        end
      end
      if (done_b) fin = 1;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (!fin || pc != 4 || pq.size() != 0) begin
      failures++;
      $display("FAIL row2_frame got=done%b pix%0d left%0d exp=done1 pix4 left0", fin, pc, pq.size());
    end
  endtask
  task automatic test_weight_and_pixels;
    run_a(0, 0, 0, 0, 0);
  endtask
  task automatic test_stall;
    run_a(1, 0, 0, 0, 0);
  endtask
  task automatic test_start_abort;
    run_a(0, 5, 0, 1, 0);
    run_a(0, 0, 0, 0, 0);
  endtask
  task automatic test_back_to_back;
    run_a(0, 0, 0, 0, 1);
    run_a(0, 0, 0, 0, 2);
  endtask
  task automatic test_reset_mid;
    run_a(0, 0, 8, 0, 0);
    run_a(0, 0, 0, 0, 0);
  endtask
  initial begin
    test_reset;
    test_weight_and_pixels;
    test_stall;
    test_row2;
    test_start_abort;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snake_scan_ctrl.md
Name: snake_scan_ctrl

Overview:
- Sequencer that feeds the first conv layer.
- After `start`, it issues the weight-load sequence: 4 filter columns x 3 PEA rows.
- It then walks the input feature map in snake order and emits row/col/linear address plus shift direction for each pixel fetch.
- It sits between the on-chip feature/weight buffers and the `chip` PE array; it replaces hand-sequenced stimulus ordering.

Parameters:
- ROW, 128, feature-map rows (must be >= 2)
- COL, 128, feature-map columns (must be >= 1)
- W_FCOL, 4, filter columns loaded (one per input channel)
- W_PROW, 3, PEA rows per filter column
- ADDR_W, $clog2(ROW*COL), linear pixel address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  synchronous return to IDLE; highest priority after reset
- w_ready  in  1  weight sink accepts current w_* beat
- w_valid  out  1  weight select beat valid
- w_fcol  out  2  filter column index of beat
- w_prow  out  2  PEA row index of beat
- px_ready  in  1  downstream accepts current pixel beat
- px_valid  out  1  pixel beat valid
- px_row  out  $clog2(ROW)  pixel row
- px_col  out  $clog2(COL)  pixel column
- px_addr  out  ADDR_W  px_row*COL+px_col
- shift_dir  out  1  0 = right-shift (col ascending), 1 = left-shift
- busy  out  1  high in WLOAD/PRIME/SNAKE
- done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, WLOAD, PRIME, SNAKE, DONE.
- IDLE -> WLOAD on start.
  - Next cycle: w_valid=1, w_fcol=0, w_prow=0.
- WLOAD sequencing:
  - A beat advances only on w_valid&&w_ready.
  - Order: w_fcol outer 0..3, w_prow inner 0..2 (12 beats).
  - The last handshake moves to PRIME; px_valid=1 the next cycle with (0,0).
- PRIME (first two rows, column-interleaved): for col 0..COL-1, row 0 then row 1.
  - Sequence: (0,0),(1,0),(0,1),(1,1),...; shift_dir=0.
- SNAKE covers rows 2..ROW-1:
  - Even row: col COL-1 down to 0, shift_dir=1.
  - Odd row: col 0 up to COL-1, shift_dir=0.
- Pixel beats advance only on px_valid&&px_ready.
  - px_* hold stable while px_valid&&!px_ready.
  - px_row, px_col, px_addr and shift_dir are registered and mutually consistent in the same cycle.
- Frame end:
  - If ROW==2, PRIME goes directly to DONE after (1,COL-1).
  - Otherwise, the last SNAKE handshake on (ROW-1, end col) goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, px_valid=0; then IDLE.
- Total pixel handshakes per frame = ROW*COL; every (row,col) is visited exactly once.
- Handshake edge cases:
  - start while busy is ignored.
  - start in DONE is ignored.
  - start in the first IDLE cycle after DONE is accepted.
- abort in any state: next cycle IDLE, all valids 0, no done pulse, counters cleared.
- rst_n low mid-frame: immediate asynchronous clear to reset values.
- No combinational path from ready inputs to valid outputs.

Decomposition:
- Shared para.v additions:
  - ROW_first_layer and COL_first_layer as the ROW/COL defaults.
  - State encoding macros SCAN_IDLE..SCAN_DONE.
  - W_FCOL/W_PROW constants.
- One sub-module, snake_addr_gen:
  - Owns the row/col/addr counters and the PRIME/SNAKE walk with an advance enable.
  - Outputs last_pix.
- The FSM and weight counters stay in the top.

Test Plan:
- ROW=4, COL=3, ready tied high, start pulse -> 12 weight beats:
  - (0,0),(0,1),(0,2),(1,0)...(3,2).
- Same configuration, pixel phase -> 12 pixel beats:
  - (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(2,2),(2,1),(2,0),(3,0),(3,1),(3,2).
  - px_addr = 0,3,1,4,2,5,8,7,6,9,10,11.
  - shift_dir = 0x6, 1x3, 0x3.
  - done pulses one cycle after the last beat.
- px_ready toggled 1/0 each cycle -> same 12-beat sequence with outputs held during stalls.
  - Frame length = 12 (WLOAD) + 24 (pixels) cycles.
- ROW=2, COL=2 -> pixels (0,0),(1,0),(0,1),(1,1) only, then done; no SNAKE cycles.
- start re-asserted during PRIME -> ignored, sequence unchanged.
  - abort at pixel 5 -> IDLE next cycle, px_valid=0, done never asserts.
  - New start -> frame restarts from weight beat (0,0).
- rst_n asserted mid-SNAKE -> outputs 0 immediately.
  - After release, idle until start; full frame then matches the ROW=4, COL=3 pixel sequence.
